// File: rtl/fifo_sync_param.sv
// fifo_sync_param
// Single-clock FIFO with configurable width and depth. It buffers operands
// and results between MAC datapath stages. Occupancy, full/empty and
// threshold flags are all registered. The overflow/underflow error flags are
// sticky until reset. flush clears the contents synchronously. FWFT selects
// the read mode: a registered read, or first-word-fall-through.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   flush         synchronous clear of contents (priority over WE/RE)
//   WE, Din       write request and write data
//   RE            read request
//   Dout          read data
//   n_full        low when count == DEPTH
//   n_empty       low when count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         current occupancy
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
module fifo_sync_param #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       WE,
  input  logic [DATA_W-1:0]          Din,
  input  logic                       RE,
  output logic [DATA_W-1:0]          Dout,
  output logic                       n_full,
  output logic                       n_empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic              rd_acc;
  logic              wr_acc;
  logic [CW-1:0]     count_nxt;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  always_comb begin
    rd_acc    = RE && n_empty;
    wr_acc    = WE && (n_full || rd_acc);
    count_nxt = count + CW'(wr_acc) - CW'(rd_acc);
    if (flush) begin
      count_nxt = '0;
    end
  end

  // ---- control / status register stage ----
  // Each flag comes from count_nxt, so it changes on the same edge as count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      n_full       <= 1'b1;
      n_empty      <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_nxt;
      n_full       <= (count_nxt != DEPTH_C);
      n_empty      <= (count_nxt != '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        // Pointer width equals log2(DEPTH), so the pointers wrap on their own.
        if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
        if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
        if (WE && !wr_acc) overflow  <= 1'b1;
        if (RE && !rd_acc) underflow <= 1'b1;
      end
    end
  end

  // ---- storage stage ----
  // The memory is not reset. Its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (!flush && wr_acc) begin
      mem[wr_ptr] <= Din;
    end
  end

  // ---- read data stage ----
  generate
    if (FWFT != 0) begin : g_fwft
      // The head word is shown while the FIFO holds data. n_empty is a
      // register, so RE and WE have no combinational path to Dout.
      assign Dout = n_empty ? mem[rd_ptr] : '0;
    end else begin : g_reg
      logic [DATA_W-1:0] dout_p1;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_p1 <= '0;
        end else if (!flush && rd_acc) begin
          dout_p1 <= mem[rd_ptr];
        end
      end
      assign Dout = dout_p1;
    end
  endgenerate

endmodule
